// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: datapath width, PC step and the fetch FSM
// state type used by the instruction fetch stage.
package cpu_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam logic [31:0] PC_INC  = 32'd4;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      MEM     = 2'd1,
      PRESENT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle between the fetch stage, the CPU and the instruction memory.
// The slave side is the fetch stage; the master side is everything around it.
interface instr_fetch_if
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) ();

   logic               cpu_waiting;
   logic               branch_valid;
   logic [31:0]        branch_target;
   logic               imem_rd;
   logic [ADDR_W-1:0]  imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic [INSTR_W-1:0] instr;
   logic               instr_valid;
   logic [31:0]        pc;

   modport slave (
      input  cpu_waiting,
      input  branch_valid,
      input  branch_target,
      input  imem_rdata,
      output imem_rd,
      output imem_addr,
      output instr,
      output instr_valid,
      output pc
   );

   modport master (
      output cpu_waiting,
      output branch_valid,
      output branch_target,
      output imem_rdata,
      input  imem_rd,
      input  imem_addr,
      input  instr,
      input  instr_valid,
      input  pc
   );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads a synchronous imem and presents
// one instruction at a time to the CPU, with branch redirect from execute.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_W   = 10,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.slave  bus
);

   fetch_state_t       state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               valid_q, valid_d;

   // Branch overrides every state; in MEM it also drops the returning word.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      if (bus.branch_valid) begin
         pc_d    = {bus.branch_target[31:2], 2'b00};
         valid_d = 1'b0;
         state_d = FETCH;
      end else begin
         unique case (state_q)
            FETCH: state_d = MEM;
            MEM: begin
               instr_d = bus.imem_rdata;
               valid_d = 1'b1;
               state_d = PRESENT;
            end
            PRESENT: begin
               if (valid_q && bus.cpu_waiting) begin
                  pc_d    = pc_q + PC_INC;
                  valid_d = 1'b0;
                  state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   // Read strobe is a decode of the state register, held off during reset.
   assign bus.imem_rd     = (state_q == FETCH) && !rst;
   assign bus.imem_addr   = pc_q[ADDR_W+1:2];
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;
   assign bus.pc          = pc_q;

endmodule
